// File: rtl/cpu_pkg.sv
// Types and constants shared by the fetcher, the sequencer and the executor.
package cpu_pkg;

  localparam int CMD_SIZE_W = 2;
  localparam int ADDR_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_EXEC    = 3'd3,
    ST_ADVANCE = 3'd4,
    ST_HALT    = 3'd5,
    ST_FAULT   = 3'd6
  } seq_state_t;

  typedef logic [1:0] fault_code_t;

  localparam fault_code_t FAULT_NONE          = 2'd0;
  localparam fault_code_t FAULT_WDT           = 2'd1;
  localparam fault_code_t FAULT_ZERO_SIZE     = 2'd2;
  localparam fault_code_t FAULT_SPURIOUS_DONE = 2'd3;

  function automatic logic is_running(input seq_state_t s);
    return (s == ST_FETCH) || (s == ST_ISSUE) || (s == ST_EXEC) || (s == ST_ADVANCE);
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Sequencer-side bundle: fetcher/executor handshakes plus run control and debug status.
interface exec_sequencer_if;
  import cpu_pkg::*;

  logic                         run;
  logic                         exe_flag;
  logic                         exe_done;
  logic        [CMD_SIZE_W-1:0] exe_cmd_size;
  logic                         exe_jmp;
  logic signed [ADDR_W-1:0]     exe_jmp_offset;
  logic                         exe_halt;

  logic                         exe_start;
  logic                         ready_flag;
  logic        [CMD_SIZE_W-1:0] prev_cmd_size;
  logic                         jmp_flag;
  logic signed [ADDR_W-1:0]     new_exe_addr_offset;
  logic                         running;
  logic                         halted;
  logic                         fault;
  fault_code_t                  fault_code;
  logic        [31:0]           instr_retired;
  logic        [31:0]           cycle_count;

  modport master (
    input  run, exe_flag, exe_done, exe_cmd_size, exe_jmp, exe_jmp_offset, exe_halt,
    output exe_start, ready_flag, prev_cmd_size, jmp_flag, new_exe_addr_offset,
           running, halted, fault, fault_code, instr_retired, cycle_count
  );

  modport slave (
    output run, exe_flag, exe_done, exe_cmd_size, exe_jmp, exe_jmp_offset, exe_halt,
    input  exe_start, ready_flag, prev_cmd_size, jmp_flag, new_exe_addr_offset,
           running, halted, fault, fault_code, instr_retired, cycle_count
  );

endinterface

// File: rtl/seq_counters.sv
// Retired-instruction and running-cycle debug counters plus the per-command watchdog.
module seq_counters #(
  parameter int WDT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_retire,
  input  logic        i_cycle,
  input  logic        i_wdt_clear,
  input  logic        i_wdt_tick,
  output logic [31:0] o_instr_retired,
  output logic [31:0] o_cycle_count,
  output logic        o_wdt_trip
);

  localparam int WDT_W = $clog2(WDT_CYCLES + 1);

  logic [31:0]      r_retired;
  logic [31:0]      r_cycles;
  logic [WDT_W-1:0] r_wdt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired <= '0;
      r_cycles  <= '0;
      r_wdt     <= '0;
    end else begin
      if (i_retire) r_retired <= r_retired + 32'd1;
      if (i_cycle)  r_cycles  <= r_cycles + 32'd1;
      if (i_wdt_clear)     r_wdt <= '0;
      else if (i_wdt_tick) r_wdt <= r_wdt + WDT_W'(1);
    end
  end

  // r_wdt counts EXEC cycles already elapsed, so the current EXEC cycle is number r_wdt+1.
  assign o_wdt_trip      = (r_wdt == WDT_W'(WDT_CYCLES - 1));
  assign o_instr_retired = r_retired;
  assign o_cycle_count   = r_cycles;

endmodule

// File: rtl/exec_sequencer.sv
// Fetch/execute loop sequencer: hands fetched commands to the executor, advances the IP,
// and owns run/pause, halt and fault handling.
module exec_sequencer
  import cpu_pkg::*;
#(
  parameter int FETCH_LAT  = 1,
  parameter int WDT_CYCLES = 1024
) (
  input logic              clk,
  input logic              rst,
  exec_sequencer_if.master bus
);

  seq_state_t               r_state, w_next;
  fault_code_t              r_fault_code, w_fault_code;
  logic                     r_fetch_first, r_flag_seen;
  logic [2:0]               r_lat_cnt;
  logic                     r_exe_start, r_ready, r_jmp;
  logic                     r_running, r_halted, r_fault;
  logic [CMD_SIZE_W-1:0]    r_size;
  logic signed [ADDR_W-1:0] r_offset;
  logic                     w_accept, w_lat_done, w_wdt_trip;
  logic                     w_retire, w_cycle, w_wdt_clear, w_wdt_tick;

  // The first FETCH cycle may still see the previous command's exe_flag.
  assign w_accept   = (r_state == ST_FETCH) && !r_fetch_first && !r_flag_seen && bus.exe_flag;
  assign w_lat_done = r_flag_seen && (r_lat_cnt == 3'(FETCH_LAT));

  always_comb begin
    w_next       = r_state;
    w_fault_code = r_fault_code;
    case (r_state)
      ST_IDLE:    if (bus.run) w_next = ST_FETCH;
      ST_FETCH:   if (w_lat_done || (w_accept && (FETCH_LAT == 0))) w_next = ST_ISSUE;
      ST_ISSUE:   w_next = ST_EXEC;
      ST_EXEC: begin
        if (bus.exe_done) begin
          if (bus.exe_halt) begin
            w_next = ST_HALT;
          end else if (!bus.exe_jmp && (bus.exe_cmd_size == '0)) begin
            w_next       = ST_FAULT;
            w_fault_code = FAULT_ZERO_SIZE;
          end else begin
            w_next = ST_ADVANCE;
          end
        end else if (w_wdt_trip) begin
          w_next       = ST_FAULT;
          w_fault_code = FAULT_WDT;
        end
      end
      ST_ADVANCE: w_next = bus.run ? ST_FETCH : ST_IDLE;
      ST_HALT, ST_FAULT: w_next = r_state;
      default:    w_next = ST_IDLE;
    endcase
    // A completion outside EXEC overrides everything except an already recorded fault.
    if (bus.exe_done && (r_state != ST_EXEC) && (r_state != ST_FAULT)) begin
      w_next       = ST_FAULT;
      w_fault_code = FAULT_SPURIOUS_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_fault_code  <= FAULT_NONE;
      r_fetch_first <= 1'b0;
      r_flag_seen   <= 1'b0;
      r_lat_cnt     <= '0;
      r_exe_start   <= 1'b0;
      r_ready       <= 1'b0;
      r_running     <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
      r_size        <= '0;
      r_jmp         <= 1'b0;
      r_offset      <= '0;
    end else begin
      r_state      <= w_next;
      r_fault_code <= w_fault_code;
      r_exe_start  <= (w_next == ST_ISSUE);
      r_ready      <= (w_next == ST_ADVANCE);
      r_running    <= is_running(w_next);
      r_halted     <= (w_next == ST_HALT);
      r_fault      <= (w_next == ST_FAULT);
      if (w_next == ST_ADVANCE) begin
        r_size   <= bus.exe_cmd_size;
        r_jmp    <= bus.exe_jmp;
        r_offset <= bus.exe_jmp_offset;
      end else begin
        r_size   <= '0;
        r_jmp    <= 1'b0;
        r_offset <= '0;
      end
      r_fetch_first <= (w_next == ST_FETCH) && (r_state != ST_FETCH);
      if (r_state != ST_FETCH) begin
        r_flag_seen <= 1'b0;
        r_lat_cnt   <= '0;
      end else if (w_accept) begin
        r_flag_seen <= 1'b1;
        r_lat_cnt   <= 3'd1;
      end else if (r_flag_seen) begin
        r_lat_cnt <= r_lat_cnt + 3'd1;
      end
    end
  end

  assign w_retire    = (w_next == ST_ADVANCE);
  assign w_cycle     = is_running(r_state);
  assign w_wdt_clear = (r_state == ST_ISSUE);
  assign w_wdt_tick  = (r_state == ST_EXEC);

  seq_counters #(
    .WDT_CYCLES (WDT_CYCLES)
  ) u_counters (
    .clk             (clk),
    .rst             (rst),
    .i_retire        (w_retire),
    .i_cycle         (w_cycle),
    .i_wdt_clear     (w_wdt_clear),
    .i_wdt_tick      (w_wdt_tick),
    .o_instr_retired (bus.instr_retired),
    .o_cycle_count   (bus.cycle_count),
    .o_wdt_trip      (w_wdt_trip)
  );

  assign bus.exe_start           = r_exe_start;
  assign bus.ready_flag          = r_ready;
  assign bus.prev_cmd_size       = r_size;
  assign bus.jmp_flag            = r_jmp;
  assign bus.new_exe_addr_offset = r_offset;
  assign bus.running             = r_running;
  assign bus.halted              = r_halted;
  assign bus.fault               = r_fault;
  assign bus.fault_code          = r_fault_code;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: directed command sequences with randomized timing and payloads,
// checked against command-level expectations (latencies, presented values, counters).
module tb_exec_sequencer;
  import cpu_pkg::*;

  localparam int FETCH_LAT  = 1;
  localparam int WDT_CYCLES = 16;

  logic clk = 1'b0;
  logic rst;

  exec_sequencer_if bus ();

  exec_sequencer #(
    .FETCH_LAT  (FETCH_LAT),
    .WDT_CYCLES (WDT_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned m_cyc     = 0;
  int unsigned m_retired = 0;
  bit          m_running = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the cycle being left counts as running if the model says so.
  task automatic step();
    if (m_running) m_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    bus.run            = 1'b0;
    bus.exe_flag       = 1'b0;
    bus.exe_done       = 1'b0;
    bus.exe_cmd_size   = '0;
    bus.exe_jmp        = 1'b0;
    bus.exe_jmp_offset = '0;
    bus.exe_halt       = 1'b0;
    step();
    rst       = 1'b0;
    m_cyc     = 0;
    m_retired = 0;
    m_running = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_exe_start"}, 32'(bus.exe_start), 32'd0);
    chk({tag, "_ready"},     32'(bus.ready_flag), 32'd0);
    chk({tag, "_size"},      32'(bus.prev_cmd_size), 32'd0);
    chk({tag, "_jmp"},       32'(bus.jmp_flag), 32'd0);
    chk({tag, "_offset"},    bus.new_exe_addr_offset, 32'd0);
    chk({tag, "_running"},   32'(bus.running), 32'd0);
    chk({tag, "_halted"},    32'(bus.halted), 32'd0);
    chk({tag, "_fault"},     32'(bus.fault), 32'd0);
    chk({tag, "_code"},      32'(bus.fault_code), 32'd0);
    chk({tag, "_retired"},   bus.instr_retired, 32'd0);
    chk({tag, "_cycles"},    bus.cycle_count, 32'd0);
  endtask

  // From IDLE with run raised: the next cycle is the first FETCH cycle.
  task automatic go_run();
    bus.run = 1'b1;
    step();
    m_running = 1'b1;
    chk("running_on", 32'(bus.running), 32'd1);
  endtask

  // Entered in the first FETCH cycle; returns in the ISSUE cycle (exe_start high).
  // stale=1 keeps exe_flag high from that first cycle, which must be ignored.
  task automatic to_issue(input bit stale, input int d, output bit ok);
    int lat;
    bus.exe_flag = stale;
    step();
    if (!stale) begin
      repeat (d) step();
      bus.exe_flag = 1'b1;
    end
    lat = -1;
    for (int r = 1; r <= 20; r++) begin
      step();
      if (bus.exe_start === 1'b1) begin
        lat = r;
        break;
      end
    end
    chk("start_latency", 32'(lat), 32'(FETCH_LAT + 1));
    ok = (lat > 0);
    if (ok) chk("issue_running", 32'(bus.running), 32'd1);
  endtask

  // Entered in the ISSUE cycle; the executor reports done k cycles after exe_start.
  task automatic finish_cmd(input int k, input logic [1:0] sz, input bit j,
                            input logic [31:0] off, input bit hlt);
    bit run_now;
    step();
    chk("start_pulse", 32'(bus.exe_start), 32'd0);
    repeat (k - 1) step();
    bus.exe_done       = 1'b1;
    bus.exe_cmd_size   = sz;
    bus.exe_jmp        = j;
    bus.exe_jmp_offset = off;
    bus.exe_halt       = hlt;
    step();
    bus.exe_done       = 1'b0;
    bus.exe_cmd_size   = 2'($urandom);
    bus.exe_jmp        = 1'($urandom);
    bus.exe_jmp_offset = $urandom;
    bus.exe_halt       = 1'($urandom);
    if (hlt) begin
      m_running = 1'b0;
      chk("halted",        32'(bus.halted), 32'd1);
      chk("halt_no_ready", 32'(bus.ready_flag), 32'd0);
      chk("halt_retired",  bus.instr_retired, m_retired);
      chk("halt_running",  32'(bus.running), 32'd0);
    end else if (!j && sz == 2'd0) begin
      m_running = 1'b0;
      chk("zero_fault",    32'(bus.fault), 32'd1);
      chk("zero_code",     32'(bus.fault_code), 32'(FAULT_ZERO_SIZE));
      chk("zero_no_ready", 32'(bus.ready_flag), 32'd0);
      chk("zero_retired",  bus.instr_retired, m_retired);
    end else begin
      m_retired++;
      chk("ready",     32'(bus.ready_flag), 32'd1);
      chk("prev_size", 32'(bus.prev_cmd_size), 32'(sz));
      chk("jmp_flag",  32'(bus.jmp_flag), 32'(j));
      chk("offset",    bus.new_exe_addr_offset, off);
      chk("retired",   bus.instr_retired, m_retired);
      run_now = bus.run;
      step();
      m_running = run_now;
      chk("ready_pulse",   32'(bus.ready_flag), 32'd0);
      chk("size_cleared",  32'(bus.prev_cmd_size), 32'd0);
      chk("offset_cleared", bus.new_exe_addr_offset, 32'd0);
      chk("running_after", 32'(bus.running), 32'(run_now));
    end
    chk("cycle_count", bus.cycle_count, m_cyc);
  endtask

  task automatic rand_cmd();
    bit         stale = 1'($urandom_range(0, 1));
    int         d     = $urandom_range(0, 3);
    int         k     = $urandom_range(1, 5);
    bit         j     = 1'($urandom_range(0, 1));
    logic [1:0] sz    = j ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 3));
    bit         ok;
    to_issue(stale, d, ok);
    if (ok) finish_cmd(k, sz, j, $urandom, 1'b0);
  endtask

  initial begin
    bit ok;
    int lat;

    // Reset state and the first command with fixed timing.
    do_reset();
    chk_all_zero("reset");
    go_run();
    to_issue(1'b0, 1, ok);
    if (ok) finish_cmd(2, 2'd2, 1'b0, 32'h0, 1'b0);

    // Backward branch, back-to-back with a stale exe_flag.
    to_issue(1'b1, 0, ok);
    if (ok) finish_cmd(1, 2'd1, 1'b1, 32'hFFFF_FFF8, 1'b0);

    repeat (6) rand_cmd();

    // Pause requested mid-command: completes, then parks in IDLE.
    to_issue(1'b0, 2, ok);
    bus.run = 1'b0;
    if (ok) finish_cmd(3, 2'd3, 1'b0, 32'h0, 1'b0);
    repeat (3) step();
    chk("paused_running", 32'(bus.running), 32'd0);
    chk("paused_cycles",  bus.cycle_count, m_cyc);
    chk("paused_retired", bus.instr_retired, m_retired);
    go_run();
    to_issue(1'b1, 0, ok);
    if (ok) finish_cmd(2, 2'd2, 1'b0, 32'h0, 1'b0);

    // Halt wins over the zero-size check and is sticky.
    to_issue(1'b0, 1, ok);
    if (ok) finish_cmd(3, 2'd0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      bus.run      = 1'($urandom);
      bus.exe_flag = 1'($urandom);
      step();
      chk("halt_sticky", 32'(bus.halted), 32'd1);
      chk("halt_no_start", 32'(bus.exe_start), 32'd0);
      chk("halt_no_ready_loop", 32'(bus.ready_flag), 32'd0);
    end
    chk("halt_retired_final", bus.instr_retired, m_retired);
    chk("halt_cycles_final",  bus.cycle_count, m_cyc);

    // Watchdog: no completion, fault WDT_CYCLES cycles after entering EXEC.
    do_reset();
    go_run();
    to_issue(1'b0, 0, ok);
    lat = -1;
    for (int r = 1; r <= 40; r++) begin
      step();
      if (bus.fault === 1'b1) begin
        lat = r;
        break;
      end
    end
    m_running = 1'b0;
    chk("wdt_latency", 32'(lat), 32'(WDT_CYCLES + 1));
    chk("wdt_code",    32'(bus.fault_code), 32'(FAULT_WDT));
    chk("wdt_running", 32'(bus.running), 32'd0);
    chk("wdt_cycles",  bus.cycle_count, m_cyc);
    bus.exe_done = 1'b1;
    step();
    bus.exe_done = 1'b0;
    chk("fault_keeps_code", 32'(bus.fault_code), 32'(FAULT_WDT));
    chk("fault_sticky",     32'(bus.fault), 32'd1);

    // Zero-size, non-jump command.
    do_reset();
    go_run();
    to_issue(1'b0, 0, ok);
    if (ok) finish_cmd(2, 2'd0, 1'b0, 32'h0, 1'b0);

    // Reset mid-EXEC after five retired commands, then a spurious completion in IDLE.
    do_reset();
    go_run();
    repeat (5) rand_cmd();
    chk("retired_five", bus.instr_retired, 32'd5);
    to_issue(1'b0, 1, ok);
    step();
    do_reset();
    chk_all_zero("rst_exec");
    bus.exe_done = 1'b1;
    step();
    bus.exe_done = 1'b0;
    chk("spurious_fault",   32'(bus.fault), 32'd1);
    chk("spurious_code",    32'(bus.fault_code), 32'(FAULT_SPURIOUS_DONE));
    chk("spurious_running", 32'(bus.running), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end of the test");
    $fatal(1, "timeout");
  end

endmodule
